// File: rtl/commu_pkg.sv
// commu_pkg: shared definitions for the commu link transmit side.
//   commu_tx_state_t : transmit FSM states
//   COMMU_DW         : link byte width
//   COMMU_CNT_W      : width of the optional completed-byte counter
package commu_pkg;

  localparam int COMMU_DW    = 8;
  localparam int COMMU_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    HIGH  = 2'd2
  } commu_tx_state_t;

endpackage

// File: rtl/commu_tx_fifo.sv
// commu_tx_fifo: synchronous show-ahead FIFO with registered full/empty flags.
// Ports:
//   clk_i, rst_i   : clock, synchronous active-high reset (empties the FIFO)
//   push_i, data_i : write request and byte; ignored while full
//   pop_i, data_o  : read request; data_o always shows the oldest entry
//   full_o         : registered full flag
//   empty_o        : registered empty flag
//   empty_nxt_o    : value empty_o takes after the current edge
module commu_tx_fifo
  import commu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                push_i,
  input  logic [COMMU_DW-1:0] data_i,
  input  logic                pop_i,
  output logic [COMMU_DW-1:0] data_o,
  output logic                full_o,
  output logic                empty_o,
  output logic                empty_nxt_o
);

  localparam int AW = $clog2(DEPTH);

  logic [COMMU_DW-1:0] mem_q [DEPTH];
  logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [AW:0]         cnt_q, cnt_d;
  logic                full_q, empty_q;
  logic                push_ok, pop_ok;

  // A push is refused whenever full, even if a pop frees a slot this cycle.
  assign push_ok = push_i && !full_q;
  assign pop_ok  = pop_i && !empty_q;

  always_comb begin
    cnt_d = cnt_q;
    if (push_ok && !pop_ok) begin
      cnt_d = cnt_q + (AW+1)'(1);
    end else if (pop_ok && !push_ok) begin
      cnt_d = cnt_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      cnt_q   <= cnt_d;
      full_q  <= (cnt_d == (AW+1)'(DEPTH));
      empty_q <= (cnt_d == '0);
    end
  end

  // Storage needs no reset: the empty flag masks stale entries.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o      = mem_q[rd_ptr_q];
  assign full_o      = full_q;
  assign empty_o     = empty_q;
  assign empty_nxt_o = (cnt_d == '0);

endmodule

// File: rtl/commu_tx.sv
// commu_tx: transmit side of the parallel commu link. Buffers bytes in a small
// FIFO and drives a divided link clock plus data so that the receiver captures
// each byte on a rising commu_clk edge. Data changes only while commu_clk falls
// or stays low, giving CLK_DIV cycles of setup and hold around each rising edge.
// Parameters: CLK_DIV (clk cycles per commu_clk half-period, >=1),
//             DEPTH (FIFO depth, power of 2, >=2).
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   in_data, in_valid  : producer byte and valid
//   in_ready           : FIFO can accept a byte (= !full)
//   commu_clk          : link clock
//   wr_en, ext_data    : link data valid and byte
//   done               : one-cycle pulse in the last HIGH cycle of each byte
//   busy               : FSM active or FIFO not empty
//   tx_count           : completed-byte counter (only with COMMU_TX_CNT_EN)
// Build option: define COMMU_TX_CNT_EN to add the tx_count port and counter.
//
// Handshake: a byte is transferred on a clk edge where in_valid && in_ready;
// the producer must hold in_data/in_valid stable until that edge.
module commu_tx
  import commu_pkg::*;
#(
  parameter int CLK_DIV = 2,
  parameter int DEPTH   = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [COMMU_DW-1:0] in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic                commu_clk,
  output logic                wr_en,
  output logic [COMMU_DW-1:0] ext_data,
  output logic                done,
  output logic                busy
`ifdef COMMU_TX_CNT_EN
  ,
  output logic [COMMU_CNT_W-1:0] tx_count
`endif
);

  localparam int CW = $clog2(CLK_DIV + 1);
  localparam logic [CW-1:0] HALF_LOAD = CW'(CLK_DIV - 1);

  commu_tx_state_t     state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                pop;
  logic                fifo_full, fifo_empty, fifo_empty_nxt;
  logic [COMMU_DW-1:0] fifo_dout;

  logic                commu_clk_q, wr_en_q, done_q, busy_q;
  logic [COMMU_DW-1:0] ext_data_q;

  commu_tx_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i       (clk),
    .rst_i       (rst),
    .push_i      (in_valid),
    .data_i      (in_data),
    .pop_i       (pop),
    .data_o      (fifo_dout),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .empty_nxt_o (fifo_empty_nxt)
  );

  assign in_ready = !fifo_full;

  // Counter counts down from CLK_DIV-1; it is reloaded on every state entry,
  // so a phase ends when it reads zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = SETUP;
          cnt_d   = HALF_LOAD;
        end
      end
      SETUP: begin
        if (cnt_q == '0) begin
          state_d = HIGH;
          cnt_d   = HALF_LOAD;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      HIGH: begin
        if (cnt_q == '0) begin
          cnt_d = HALF_LOAD;
          // Chain straight into the next byte so back-to-back bytes have no gap.
          if (!fifo_empty) begin
            pop     = 1'b1;
            state_d = SETUP;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = HALF_LOAD;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      commu_clk_q <= 1'b0;
      wr_en_q     <= 1'b0;
      ext_data_q  <= '0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      commu_clk_q <= (state_d == HIGH);
      wr_en_q     <= (state_d != IDLE);
      if (pop) ext_data_q <= fifo_dout;
      done_q      <= (state_d == HIGH) && (cnt_d == '0);
      busy_q      <= (state_d != IDLE) || !fifo_empty_nxt;
    end
  end

  assign commu_clk = commu_clk_q;
  assign wr_en     = wr_en_q;
  assign ext_data  = ext_data_q;
  assign done      = done_q;
  assign busy      = busy_q;

`ifdef COMMU_TX_CNT_EN
  logic [COMMU_CNT_W-1:0] tx_cnt_q;

  // Advances together with done; wraps naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_cnt_q <= '0;
    end else if ((state_d == HIGH) && (cnt_d == '0)) begin
      tx_cnt_q <= tx_cnt_q + COMMU_CNT_W'(1);
    end
  end

  assign tx_count = tx_cnt_q;
`endif

endmodule

// File: tb/tb_commu_tx.sv
module tb_commu_tx;
  import commu_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUTs: CLK_DIV=2 and CLK_DIV=1 ----------------
  logic [7:0] d2_in_data = '0, d1_in_data = '0;
  logic       d2_in_valid = 1'b0, d1_in_valid = 1'b0;
  logic       d2_in_ready, d2_commu_clk, d2_wr_en, d2_done, d2_busy;
  logic       d1_in_ready, d1_commu_clk, d1_wr_en, d1_done, d1_busy;
  logic [7:0] d2_ext_data, d1_ext_data;
`ifdef COMMU_TX_CNT_EN
  logic [COMMU_CNT_W-1:0] d2_tx_count, d1_tx_count;
`endif

  commu_tx #(.CLK_DIV(2), .DEPTH(4)) dut2 (
    .clk(clk), .rst(rst), .in_data(d2_in_data), .in_valid(d2_in_valid),
    .in_ready(d2_in_ready), .commu_clk(d2_commu_clk), .wr_en(d2_wr_en),
    .ext_data(d2_ext_data), .done(d2_done), .busy(d2_busy)
`ifdef COMMU_TX_CNT_EN
    , .tx_count(d2_tx_count)
`endif
  );

  commu_tx #(.CLK_DIV(1), .DEPTH(4)) dut1 (
    .clk(clk), .rst(rst), .in_data(d1_in_data), .in_valid(d1_in_valid),
    .in_ready(d1_in_ready), .commu_clk(d1_commu_clk), .wr_en(d1_wr_en),
    .ext_data(d1_ext_data), .done(d1_done), .busy(d1_busy)
`ifdef COMMU_TX_CNT_EN
    , .tx_count(d1_tx_count)
`endif
  );

  // ---------------- check bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- scoreboard / receiver model on dut2 ----------------
  logic [7:0] exp_q[$];
  int         rise_cyc[$];
  int         done_cnt = 0;
  int         rx_cnt   = 0;
  logic       prev_cclk = 1'b0;
  logic [7:0] prev_ext  = '0;

  always @(negedge clk) begin
    if (d2_commu_clk && !prev_cclk) begin
      rise_cyc.push_back(cyc);
      rx_cnt++;
      check("rx_wr_en_at_rise", d2_wr_en, 1'b1);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL rx_unexpected: got 0x%0h expected no byte (cycle %0d)", d2_ext_data, cyc);
      end else begin
        check("rx_byte", d2_ext_data, exp_q.pop_front());
      end
    end
    if (d2_ext_data !== prev_ext) check("ext_change_while_clk_low", d2_commu_clk, 1'b0);
    if (d2_done) done_cnt++;
    prev_cclk = d2_commu_clk;
    prev_ext  = d2_ext_data;
  end

  // ---------------- vector tables ----------------
  typedef struct {
    int         dut;
    logic       cclk;
    logic       wr;
    logic [7:0] ext;
    logic       dn;
    logic       bsy;
  } vec_t;

  vec_t t_single[$];
  vec_t t_div1[$];

  function automatic vec_t mk(input int d, input logic c, input logic w,
                              input logic [7:0] e, input logic dn, input logic b);
    vec_t v;
    v.dut = d; v.cclk = c; v.wr = w; v.ext = e; v.dn = dn; v.bsy = b;
    return v;
  endfunction

  task automatic apply_row(input string tag, input vec_t v);
    if (v.dut == 2) begin
      check({tag, "_commu_clk"}, d2_commu_clk, v.cclk);
      check({tag, "_wr_en"},     d2_wr_en,     v.wr);
      check({tag, "_ext_data"},  d2_ext_data,  v.ext);
      check({tag, "_done"},      d2_done,      v.dn);
      check({tag, "_busy"},      d2_busy,      v.bsy);
    end else begin
      check({tag, "_commu_clk"}, d1_commu_clk, v.cclk);
      check({tag, "_wr_en"},     d1_wr_en,     v.wr);
      check({tag, "_ext_data"},  d1_ext_data,  v.ext);
      check({tag, "_done"},      d1_done,      v.dn);
      check({tag, "_busy"},      d1_busy,      v.bsy);
    end
  endtask

  // Wait (bounded) for dut2 to go idle; an expired bound counts as a failure.
  task automatic wait_idle2(input int max_cyc);
    int n;
    n = 0;
    while (d2_busy && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check("idle_wait_timeout", d2_busy, 1'b0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- main test ----------------
  initial begin
    int payload, accepted, first_drop, waitn, done_snap, rise_snap;

    // Single byte 0xA5 on CLK_DIV=2, rows are cycles 1..6 after the push cycle.
    t_single.push_back(mk(2, 0, 0, 8'h00, 0, 1));
    t_single.push_back(mk(2, 0, 1, 8'hA5, 0, 1));
    t_single.push_back(mk(2, 0, 1, 8'hA5, 0, 1));
    t_single.push_back(mk(2, 1, 1, 8'hA5, 0, 1));
    t_single.push_back(mk(2, 1, 1, 8'hA5, 1, 1));
    t_single.push_back(mk(2, 0, 0, 8'hA5, 0, 0));
    // Two bytes 0x3C, 0xC3 on CLK_DIV=1, cycles 1..6.
    t_div1.push_back(mk(1, 0, 0, 8'h00, 0, 1));
    t_div1.push_back(mk(1, 0, 1, 8'h3C, 0, 1));
    t_div1.push_back(mk(1, 1, 1, 8'h3C, 1, 1));
    t_div1.push_back(mk(1, 0, 1, 8'hC3, 0, 1));
    t_div1.push_back(mk(1, 1, 1, 8'hC3, 1, 1));
    t_div1.push_back(mk(1, 0, 0, 8'hC3, 0, 0));

    // ---- reset state ----
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_commu_clk", d2_commu_clk, 1'b0);
    check("rst_wr_en",     d2_wr_en,     1'b0);
    check("rst_ext_data",  d2_ext_data,  8'h00);
    check("rst_done",      d2_done,      1'b0);
    check("rst_busy",      d2_busy,      1'b0);
    check("rst_in_ready",  d2_in_ready,  1'b1);
`ifdef COMMU_TX_CNT_EN
    check("rst_tx_count",  d2_tx_count,  16'h0000);
`endif

    // ---- single byte timing ----
    @(negedge clk);
    d2_in_valid = 1'b1; d2_in_data = 8'hA5; exp_q.push_back(8'hA5);
    foreach (t_single[i]) begin
      @(negedge clk);
      d2_in_valid = 1'b0;
      apply_row($sformatf("single_c%0d", i + 1), t_single[i]);
    end
    check("single_sb_empty", exp_q.size(), 0);

    // ---- three bytes back-to-back ----
    rise_cyc.delete();
    d2_in_valid = 1'b1; d2_in_data = 8'h11; exp_q.push_back(8'h11);
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (k == 1) begin d2_in_data = 8'h22; exp_q.push_back(8'h22); end
      if (k == 2) begin d2_in_data = 8'h33; exp_q.push_back(8'h33); end
      if (k == 3) d2_in_valid = 1'b0;
      if (k >= 2 && k <= 13) begin
        check($sformatf("b2b_wr_en_c%0d", k), d2_wr_en, 1'b1);
        check($sformatf("b2b_commu_clk_c%0d", k), d2_commu_clk, ((k - 2) % 4) >= 2);
      end
    end
    check("b2b_busy_end", d2_busy, 1'b0);
    check("b2b_rises", rise_cyc.size(), 3);
    if (rise_cyc.size() == 3) begin
      check("b2b_period_1", rise_cyc[1] - rise_cyc[0], 4);
      check("b2b_period_2", rise_cyc[2] - rise_cyc[1], 4);
    end
    check("b2b_sb_empty", exp_q.size(), 0);

    // ---- flow control: hold valid with incrementing payload ----
    payload = 8'h40; accepted = 0; first_drop = -1; waitn = 0; rx_cnt = 0;
    while (accepted < 20 && waitn < 1000) begin
      d2_in_valid = 1'b1;
      d2_in_data  = payload[7:0];
      if (d2_in_ready) begin
        exp_q.push_back(payload[7:0]);
        accepted++;
        payload++;
      end else if (first_drop < 0) begin
        first_drop = accepted;
      end
      @(negedge clk);
      waitn++;
    end
    d2_in_valid = 1'b0;
    check("flow_accepted", accepted, 20);
    check("flow_first_drop", first_drop, 5);
    wait_idle2(500);
    check("flow_rx_count", rx_cnt, 20);
    check("flow_sb_empty", exp_q.size(), 0);

    // ---- CLK_DIV=1, two bytes ----
    d1_in_valid = 1'b1; d1_in_data = 8'h3C;
    foreach (t_div1[i]) begin
      @(negedge clk);
      if (i == 0) d1_in_data = 8'hC3;
      if (i == 1) d1_in_valid = 1'b0;
      apply_row($sformatf("div1_c%0d", i + 1), t_div1[i]);
    end

    // ---- reset in first HIGH cycle with bytes queued ----
    @(negedge clk);
    d2_in_valid = 1'b1; d2_in_data = 8'h5A; exp_q.push_back(8'h5A);
    @(negedge clk);
    d2_in_data = 8'h66; exp_q.push_back(8'h66);
    @(negedge clk);
    d2_in_data = 8'h77; exp_q.push_back(8'h77);
    @(negedge clk);
    d2_in_valid = 1'b0;
    waitn = 0;
    while (!d2_commu_clk && waitn < 20) begin
      @(negedge clk);
      waitn++;
    end
    check("rstmid_reached_high", d2_commu_clk, 1'b1);
    check("rstmid_byte_in_high", d2_ext_data, 8'h5A);
    rst = 1'b1;
    @(negedge clk);
    exp_q.delete();
    check("rstmid_commu_clk", d2_commu_clk, 1'b0);
    check("rstmid_wr_en",     d2_wr_en,     1'b0);
    check("rstmid_ext_data",  d2_ext_data,  8'h00);
    check("rstmid_in_ready",  d2_in_ready,  1'b1);
    check("rstmid_done",      d2_done,      1'b0);
    check("rstmid_busy",      d2_busy,      1'b0);
    rst = 1'b0;
    done_snap = done_cnt;
    rise_snap = rise_cyc.size();
    repeat (12) @(negedge clk);
    check("rstmid_no_done",  done_cnt, done_snap);
    check("rstmid_no_rise",  rise_cyc.size(), rise_snap);
    check("rstmid_idle",     d2_busy, 1'b0);

`ifdef COMMU_TX_CNT_EN
    // ---- counter wrap ----
    force dut2.tx_cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut2.tx_cnt_q;
    @(negedge clk);
    check("cnt_preload", d2_tx_count, 16'hFFFF);
    d2_in_valid = 1'b1; d2_in_data = 8'hE7; exp_q.push_back(8'hE7);
    @(negedge clk);
    d2_in_valid = 1'b0;
    wait_idle2(50);
    check("cnt_wrap", d2_tx_count, 16'h0000);
`endif

    check("final_sb_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
